// File: rtl/priv_1_13_int_ctrl_n.sv
// Interrupt controller: pending latch, privilege/delegation gating, fixed-priority
// arbitration and the req/pipe_clear/commit trap-entry handshake.
module priv_1_13_int_ctrl_n #(
  parameter int                          NUM_LOCAL = 4,
  parameter logic [16+NUM_LOCAL-1:0]     EDGE_MASK = '0,
  parameter int                          CAUSE_W   = 6
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [16+NUM_LOCAL-1:0]    int_raw,
  input  logic [16+NUM_LOCAL-1:0]    int_clear,
  input  logic [16+NUM_LOCAL-1:0]    mie_en,
  input  logic [16+NUM_LOCAL-1:0]    mideleg,
  input  logic                       mstatus_mie,
  input  logic                       mstatus_sie,
  input  logic [1:0]                 priv_level,
  input  logic                       ex_pending,
  input  logic                       pipe_clear,
  output logic [16+NUM_LOCAL-1:0]    mip_q,
  output logic                       trap_req,
  output logic                       trap_commit,
  output logic [CAUSE_W-1:0]         trap_cause,
  output logic                       trap_to_s,
  output logic                       busy
);

  localparam int NUM_INT = 16 + NUM_LOCAL;
  localparam int STD_ORDER [6] = '{11, 3, 7, 9, 1, 5};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_INT-1:0]   r_mip;
  logic [NUM_INT-1:0]   r_raw_d;
  logic [NUM_INT-1:0]   w_rise;
  logic [NUM_INT-1:0]   w_act;
  logic [NUM_INT-1:0]   w_elig_m;
  logic [NUM_INT-1:0]   w_elig_s;
  logic [NUM_INT-1:0]   w_elig;
  logic [CAUSE_W-1:0]   r_cause;
  logic [CAUSE_W-1:0]   w_win;
  logic                 r_to_s;
  logic                 w_m_ok;
  logic                 w_s_ok;
  logic                 w_any;
  logic                 w_win_s;
  logic                 w_latch;
  logic                 w_still;

  assign w_rise   = int_raw & ~r_raw_d;
  assign w_m_ok   = (priv_level != 2'd3) | mstatus_mie;
  assign w_s_ok   = (priv_level == 2'd0) | ((priv_level == 2'd1) & mstatus_sie);
  assign w_act    = r_mip & mie_en;
  assign w_elig_m = w_act & ~mideleg & {NUM_INT{w_m_ok}};
  assign w_elig_s = w_act &  mideleg & {NUM_INT{w_s_ok}};
  assign w_elig   = w_elig_m | w_elig_s;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    w_any   = 1'b0;
    w_win   = '0;
    w_win_s = 1'b0;
    for (int k = 5; k >= 0; k--) begin
      if (w_elig_s[STD_ORDER[k]]) begin
        w_any = 1'b1; w_win = CAUSE_W'(STD_ORDER[k]); w_win_s = 1'b1;
      end
    end
    for (int i = 16; i < NUM_INT; i++) begin
      if (w_elig_s[i]) begin
        w_any = 1'b1; w_win = CAUSE_W'(i); w_win_s = 1'b1;
      end
    end
    for (int k = 5; k >= 0; k--) begin
      if (w_elig_m[STD_ORDER[k]]) begin
        w_any = 1'b1; w_win = CAUSE_W'(STD_ORDER[k]); w_win_s = 1'b0;
      end
    end
    for (int i = 16; i < NUM_INT; i++) begin
      if (w_elig_m[i]) begin
        w_any = 1'b1; w_win = CAUSE_W'(i); w_win_s = 1'b0;
      end
    end
  end

  always_comb begin
    w_still = 1'b0;
    for (int i = 0; i < NUM_INT; i++) begin
      if (r_cause == CAUSE_W'(i)) w_still = w_elig[i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any && !ex_pending) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ex_pending || !w_still) w_state_nxt = ST_IDLE;
        else if (pipe_clear)        w_state_nxt = ST_COMMIT;
      end
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_mip   <= '0;
      r_raw_d <= '0;
      r_cause <= '0;
      r_to_s  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_raw_d <= int_raw;
      // A new edge beats a same-cycle clear; level sources just follow the line.
      r_mip   <= (int_raw & ~EDGE_MASK) | (EDGE_MASK & (w_rise | (r_mip & ~int_clear)));
      if (w_latch) begin
        r_cause <= w_win;
        r_to_s  <= w_win_s;
      end
    end
  end

  assign mip_q       = r_mip;
  assign trap_req    = (r_state == ST_REQ);
  assign trap_commit = (r_state == ST_COMMIT);
  assign trap_cause  = r_cause;
  assign trap_to_s   = r_to_s;
  assign busy        = (r_state != ST_IDLE);

endmodule
